// File: rtl/ecc_pkg.sv
// Shared definitions for the GF(2^233) multiplier request controller.
package ecc_pkg;

    localparam int unsigned N_FIELD = 233;
    localparam int unsigned ST_W    = 2;

    localparam logic [ST_W-1:0] ST_OK      = 2'b00;
    localparam logic [ST_W-1:0] ST_FAULT   = 2'b01;
    localparam logic [ST_W-1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/mul_req_ctrl.sv
// Initiator-side controller: turns valid/ready multiply jobs into the
// multiplier's one-shot pulse protocol, supervises ERROR/timeout, and
// returns product plus status on a valid/ready response channel.
module mul_req_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned N       = N_FIELD,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned MAX_ERR = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [N-1:0]    REQ_A,
    input  logic [N-1:0]    REQ_B,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [N-1:0]    RSP_DATA,
    output logic [ST_W-1:0] RSP_STATUS,
    output logic            M_IN_VALID,
    output logic [N-1:0]    M_A,
    output logic [N-1:0]    M_B,
    input  logic [N-1:0]    M_DOUT,
    input  logic            M_OUT_VALID,
    input  logic            M_ERROR,
    output logic [15:0]     ERR_TOTAL
);

    localparam int unsigned ERR_W  = 4;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned TOT_W  = 16;

    localparam logic [ERR_W-1:0]  ERR_LIM  = ERR_W'(MAX_ERR);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

    state_e             state_q,      state_d;
    logic               m_in_valid_q, m_in_valid_d;
    logic [N-1:0]       m_a_q,        m_a_d;
    logic [N-1:0]       m_b_q,        m_b_d;
    logic               rsp_valid_q,  rsp_valid_d;
    logic [N-1:0]       rsp_data_q,   rsp_data_d;
    logic [ST_W-1:0]    rsp_status_q, rsp_status_d;
    logic [ERR_W-1:0]   err_cnt_q,    err_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q,   wait_cnt_d;
    logic [TOT_W-1:0]   err_total_q,  err_total_d;

    // State register and datapath flops, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            m_in_valid_q <= 1'b0;
            m_a_q        <= '0;
            m_b_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            err_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            err_total_q  <= '0;
        end else begin
            state_q      <= state_d;
            m_in_valid_q <= m_in_valid_d;
            m_a_q        <= m_a_d;
            m_b_q        <= m_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            err_cnt_q    <= err_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            err_total_q  <= err_total_d;
        end
    end

    // Next-state logic; in WAIT, OUT_VALID beats ERROR, which beats the timeout count.
    always_comb begin
        state_d      = state_q;
        m_in_valid_d = 1'b0;
        m_a_d        = m_a_q;
        m_b_d        = m_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        err_cnt_d    = err_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        err_total_d  = err_total_q;

        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    m_a_d        = REQ_A;
                    m_b_d        = REQ_B;
                    err_cnt_d    = '0;
                    wait_cnt_d   = '0;
                    m_in_valid_d = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // ERROR here may belong to an aborted job still running; ignore it.
                state_d = WAIT;
            end
            WAIT: begin
                if (M_OUT_VALID) begin
                    rsp_data_d   = M_DOUT;
                    rsp_status_d = ST_OK;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else if (M_ERROR) begin
                    err_cnt_d  = err_cnt_q + ERR_W'(1);
                    wait_cnt_d = '0;
                    if (err_total_q != {TOT_W{1'b1}}) begin
                        err_total_d = err_total_q + TOT_W'(1);
                    end
                    if (err_cnt_q + ERR_W'(1) == ERR_LIM) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_FAULT;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q + WAIT_W'(1) == WAIT_LIM) begin
                        rsp_data_d   = '0;
                        rsp_status_d = ST_TIMEOUT;
                        rsp_valid_d  = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign REQ_READY  = (state_q == IDLE);
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_DATA   = rsp_data_q;
    assign RSP_STATUS = rsp_status_q;
    assign M_IN_VALID = m_in_valid_q;
    assign M_A        = m_a_q;
    assign M_B        = m_b_q;
    assign ERR_TOTAL  = err_total_q;

endmodule
